// File: rtl/square_plotter.sv
// square_plotter
//   Pixel back end for the square animation FSMs. Each request accepted on
//   a plot/ready handshake is rasterised into SIZE x SIZE pixel writes,
//   row-major, one per clock, on the frame buffer adapter's write port.
//
//   state | meaning
//   IDLE  | waiting for a request, ready=1
//   DRAW  | presenting one pixel per cycle from the latched request
//   DONE  | one-cycle completion pulse on done, no write
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   plot                   request valid, held with its fields until accepted
//   starting_x/_y, colour  request: square origin and fill colour
//   ready                  request can be accepted this cycle (state==IDLE)
//   x, y, colour_out       pixel being written (x/y hold outside DRAW)
//   writeEn                pixel write strobe, low for clipped pixels
//   done                   one-cycle pulse after the last pixel of a square
module square_plotter #(
    parameter int SIZE  = 4,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             plot,
    input  logic [X_W-1:0]   starting_x,
    input  logic [Y_W-1:0]   starting_y,
    input  logic [COL_W-1:0] colour,
    output logic             ready,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour_out,
    output logic             writeEn,
    output logic             done
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t           state, nxt_state;
    logic [X_W-1:0]   sx, nxt_sx;
    logic [Y_W-1:0]   sy, nxt_sy;
    logic [COL_W-1:0] col, nxt_col;
    logic [CW-1:0]    cx, nxt_cx;
    logic [CW-1:0]    cy, nxt_cy;
    logic [X_W-1:0]   nxt_x;
    logic [Y_W-1:0]   nxt_y;
    logic [COL_W-1:0] nxt_colour_out;
    logic             nxt_we, nxt_done, load_px;
    logic [X_W:0]     sum_x;
    logic [Y_W:0]     sum_y;

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sx         <= '0;
            sy         <= '0;
            col        <= '0;
            cx         <= '0;
            cy         <= '0;
            x          <= '0;
            y          <= '0;
            colour_out <= '0;
            writeEn    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt_state;
            sx         <= nxt_sx;
            sy         <= nxt_sy;
            col        <= nxt_col;
            cx         <= nxt_cx;
            cy         <= nxt_cy;
            x          <= nxt_x;
            y          <= nxt_y;
            colour_out <= nxt_colour_out;
            writeEn    <= nxt_we;
            done       <= nxt_done;
        end
    end

    // Outputs are registered, so the pixel shown in a cycle is computed in
    // the cycle before: on accept the first pixel comes straight from the
    // request inputs, afterwards from the latched copy and the next counters.
    always_comb begin
        nxt_state      = state;
        nxt_sx         = sx;
        nxt_sy         = sy;
        nxt_col        = col;
        nxt_cx         = cx;
        nxt_cy         = cy;
        nxt_x          = x;
        nxt_y          = y;
        nxt_colour_out = colour_out;
        nxt_we         = 1'b0;
        nxt_done       = 1'b0;
        load_px        = 1'b0;

        case (state)
            IDLE: begin
                if (plot) begin
                    nxt_state      = DRAW;
                    nxt_sx         = starting_x;
                    nxt_sy         = starting_y;
                    nxt_col        = colour;
                    nxt_cx         = '0;
                    nxt_cy         = '0;
                    nxt_colour_out = colour;
                    load_px        = 1'b1;
                end
            end
            DRAW: begin
                if (cx == LAST && cy == LAST) begin
                    nxt_state = DONE;
                    nxt_done  = 1'b1;
                end else begin
                    if (cx == LAST) begin
                        nxt_cx = '0;
                        nxt_cy = cy + CW'(1);
                    end else begin
                        nxt_cx = cx + CW'(1);
                    end
                    load_px = 1'b1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        // One extra bit so an off-screen pixel is detected instead of wrapping.
        sum_x = (X_W+1)'(nxt_sx) + (X_W+1)'(nxt_cx);
        sum_y = (Y_W+1)'(nxt_sy) + (Y_W+1)'(nxt_cy);

        if (load_px) begin
            nxt_x  = sum_x[X_W-1:0];
            nxt_y  = sum_y[Y_W-1:0];
            nxt_we = (sum_x <= (X_W+1)'(X_MAX)) && (sum_y <= (Y_W+1)'(Y_MAX));
        end
    end

endmodule

// File: tb/tb_square_plotter.sv
module tb_square_plotter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       plot = 1'b0;
    logic       plot1 = 1'b0;
    logic [7:0] sx_in = '0;
    logic [6:0] sy_in = '0;
    logic [2:0] col_in = '0;

    logic       ready, we, done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;

    logic       ready1, we1, done1;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] c1;

    int errors = 0;
    int checks = 0;
    int writes = 0;

    always #5 clk = ~clk;

    square_plotter dut (
        .clk(clk), .resetn(resetn), .plot(plot),
        .starting_x(sx_in), .starting_y(sy_in), .colour(col_in),
        .ready(ready), .x(x), .y(y), .colour_out(colour_out),
        .writeEn(we), .done(done)
    );

    square_plotter #(.SIZE(1)) dut1 (
        .clk(clk), .resetn(resetn), .plot(plot1),
        .starting_x(sx_in), .starting_y(sy_in), .colour(col_in),
        .ready(ready1), .x(x1), .y(y1), .colour_out(c1),
        .writeEn(we1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1ns after an edge with the DUT idle; returns in the ready cycle.
    task automatic square(input logic [7:0] ox, input logic [6:0] oy, input logic [2:0] c,
                          input bit hold, input logic [7:0] nx, input logic [6:0] ny,
                          input logic [2:0] nc, input bit disturb);
        int px, py;
        chk("pre_ready", ready, 1);
        sx_in = ox; sy_in = oy; col_in = c; plot = 1'b1;
        step();
        if (hold) begin
            sx_in = nx; sy_in = ny; col_in = nc;
        end else begin
            plot = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            px = int'(ox) + i % 4;
            py = int'(oy) + i / 4;
            chk("busy", ready, 0);
            chk("px_x", x, px & 32'hff);
            chk("px_y", y, py & 32'h7f);
            chk("px_col", colour_out, c);
            chk("px_we", we, (px <= 159 && py <= 119) ? 1 : 0);
            chk("px_done", done, 0);
            if (we) writes++;
            if (disturb) begin
                sx_in  = 8'($urandom);
                col_in = 3'($urandom);
                plot   = ~plot;
            end
            step();
        end
        chk("done_pulse", done, 1);
        chk("done_we", we, 0);
        chk("done_ready", ready, 0);
        if (disturb) plot = 1'b0;
        step();
        chk("done_clear", done, 0);
        chk("ready_back", ready, 1);
    endtask

    initial begin
        int pulses;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_we", we, 0);
        chk("rst_done", done, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_col", colour_out, 0);
        step();
        resetn = 1'b1;
        step();

        // basic square, RED
        writes = 0;
        square(8'd10, 7'd112, 3'b100, 1'b0, '0, '0, '0, 1'b0);
        chk("basic_writes", writes, 16);

        // back-to-back with plot held, YELLOW then BLACK
        writes = 0;
        square(8'd20, 7'd112, 3'b110, 1'b1, 8'd30, 7'd112, 3'b000, 1'b0);
        square(8'd30, 7'd112, 3'b000, 1'b0, '0, '0, '0, 1'b0);
        chk("b2b_writes", writes, 32);

        // clipping at the bottom-right corner, GREEN
        writes = 0;
        square(8'd158, 7'd118, 3'b010, 1'b0, '0, '0, '0, 1'b0);
        chk("clip_writes", writes, 4);

        // inputs disturbed during DRAW
        square(8'd50, 7'd60, 3'b101, 1'b0, '0, '0, '0, 1'b1);
        step();
        chk("no_extra_accept", ready, 1);

        // reset in the 7th pixel cycle
        sx_in = 8'd10; sy_in = 7'd20; col_in = 3'b101; plot = 1'b1;
        step();
        plot = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("p7_we", we, 1);
        chk("p7_x", x, 12);
        chk("p7_y", y, 21);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_col", colour_out, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        step();
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || we) pulses++;
        end
        chk("no_done_after_rst", pulses, 0);
        writes = 0;
        square(8'd40, 7'd50, 3'b011, 1'b0, '0, '0, '0, 1'b0);
        chk("post_rst_writes", writes, 16);

        // SIZE=1 instance, BLUE at origin
        sx_in = 8'd0; sy_in = 7'd0; col_in = 3'b001;
        chk("s1_ready", ready1, 1);
        plot1 = 1'b1;
        step();
        plot1 = 1'b0;
        chk("s1_we", we1, 1);
        chk("s1_x", x1, 0);
        chk("s1_y", y1, 0);
        chk("s1_col", c1, 1);
        chk("s1_busy", ready1, 0);
        step();
        chk("s1_done", done1, 1);
        chk("s1_done_we", we1, 0);
        step();
        chk("s1_ready_back", ready1, 1);
        chk("s1_done_clear", done1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
